// File: rtl/edge_bank_rs_arbiter_pkg.sv
// Shared types and sizing for the edge-bank to reservation-station arbiter.
// Holds the bank beat struct, the arbiter state enum, the array sizes and a
// helper that extracts one bank's beat from the flattened bank buses.
package edge_bank_rs_arbiter_pkg;

    localparam int NUM_BANK  = 4;
    localparam int FV_SIZE   = 16;
    localparam int NODE_ID_W = 10;
    localparam int MAX_BEATS = 16;

    localparam int PTR_W  = $clog2(NUM_BANK);
    localparam int CNT_W  = $clog2(MAX_BEATS) + 1;
    localparam int BEAT_W = 2 * FV_SIZE;

    // One beat as a bank presents it to the RS port
    typedef struct packed {
        logic                          sos;
        logic                          eos;
        logic [1:0][FV_SIZE-1:0]       fv_data;
        logic [NODE_ID_W-1:0]          node_id;
    } bank2rs_t;

    typedef enum logic {
        ARB    = 1'b0,
        STREAM = 1'b1
    } arb_state_e;

    // Gather bank 'sel' out of the flattened per-bank buses
    function automatic bank2rs_t pick_beat(
        input logic [NUM_BANK-1:0]           sos,
        input logic [NUM_BANK-1:0]           eos,
        input logic [NUM_BANK*BEAT_W-1:0]    data,
        input logic [NUM_BANK*NODE_ID_W-1:0] node,
        input logic [PTR_W-1:0]              sel
    );
        bank2rs_t beat;
        beat.sos     = sos[sel];
        beat.eos     = eos[sel];
        beat.fv_data = data[int'(sel) * BEAT_W +: BEAT_W];
        beat.node_id = node[int'(sel) * NODE_ID_W +: NODE_ID_W];
        return beat;
    endfunction

endpackage

// File: rtl/edge_bank_rs_arbiter_if.sv
// Bank-array / RS handshake bundle. The master modport is the arbiter's view
// (drives grants and the RS beat); the slave modport is the environment's view.
interface edge_bank_rs_arbiter_if;
    import edge_bank_rs_arbiter_pkg::*;

    logic [NUM_BANK-1:0]           bank_req;
    logic [NUM_BANK-1:0]           bank_sos;
    logic [NUM_BANK-1:0]           bank_eos;
    logic [NUM_BANK*BEAT_W-1:0]    bank_data;
    logic [NUM_BANK*NODE_ID_W-1:0] bank_node_id;
    logic                          rs_ready;
    logic [NUM_BANK-1:0]           bank_grant;
    logic                          rs_valid;
    logic                          rs_sos;
    logic                          rs_eos;
    logic [BEAT_W-1:0]             rs_data;
    logic [NODE_ID_W-1:0]          rs_node_id;

    modport master (
        input  bank_req, bank_sos, bank_eos, bank_data, bank_node_id, rs_ready,
        output bank_grant, rs_valid, rs_sos, rs_eos, rs_data, rs_node_id
    );

    modport slave (
        output bank_req, bank_sos, bank_eos, bank_data, bank_node_id, rs_ready,
        input  bank_grant, rs_valid, rs_sos, rs_eos, rs_data, rs_node_id
    );

endinterface

// File: rtl/edge_bank_rs_arbiter_rr_priority_pick.sv
// Round-robin priority picker: first set request at or above ptr, wrapping.
// Purely combinational; NUM_BANK is a power of two so index wrap is free.
module rr_priority_pick
    import edge_bank_rs_arbiter_pkg::*;
(
    input  logic [NUM_BANK-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NUM_BANK-1:0] onehot,
    output logic [PTR_W-1:0]    idx,
    output logic                any_req
);

    // Scan candidates ptr, ptr+1, ... and keep the first requester found
    always_comb begin
        logic [PTR_W-1:0] cand_s;
        onehot  = {NUM_BANK{1'b0}};
        idx     = {PTR_W{1'b0}};
        any_req = 1'b0;
        cand_s  = {PTR_W{1'b0}};
        for (int i = 0; i < NUM_BANK; i++) begin
            cand_s = ptr + PTR_W'(i);
            if (!any_req && req[cand_s]) begin
                any_req        = 1'b1;
                idx            = cand_s;
                onehot[cand_s] = 1'b1;
            end else begin
                // an earlier candidate already won; leave the result alone
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/edge_bank_rs_arbiter.sv
// Edge-bank to reservation-station arbiter. Grants one bank round-robin,
// locks onto it until eos and forwards its beats through one register stage.
// Optional build macro EDGE_ARB_TIMEOUT_EN: a stream reaching MAX_BEATS beats
// without eos is force-terminated (rs_eos=1 on that beat) and the FSM rearms.
module edge_bank_rs_arbiter
    import edge_bank_rs_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    edge_bank_rs_arbiter_if.master arb_if,
    output logic                   busy,
    output logic                   proto_err
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    arb_state_e           state_r, state_s;
    logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_s;
    logic [PTR_W-1:0]     owner_r, owner_s;
    logic [CNT_W-1:0]     beat_cnt_r, beat_cnt_s;
    logic                 proto_err_r, err_s;

    logic                 rs_valid_r, rs_valid_s;
    logic                 rs_sos_r, rs_sos_s;
    logic                 rs_eos_r, rs_eos_s;
    logic [BEAT_W-1:0]    rs_data_r, rs_data_s;
    logic [NODE_ID_W-1:0] rs_node_id_r, rs_node_id_s;

    logic [NUM_BANK-1:0]  win_onehot_s;
    logic [PTR_W-1:0]     win_idx_s;
    logic                 any_req_s;
    logic [NUM_BANK-1:0]  grant_s;
    logic                 last_slot_s;
    bank2rs_t             win_beat_s;
    bank2rs_t             own_beat_s;

    rr_priority_pick u_pick (
        .req     (arb_if.bank_req),
        .ptr     (rr_ptr_r),
        .onehot  (win_onehot_s),
        .idx     (win_idx_s),
        .any_req (any_req_s)
    );

    assign win_beat_s = pick_beat(arb_if.bank_sos, arb_if.bank_eos, arb_if.bank_data,
                                  arb_if.bank_node_id, win_idx_s);
    assign own_beat_s = pick_beat(arb_if.bank_sos, arb_if.bank_eos, arb_if.bank_data,
                                  arb_if.bank_node_id, owner_r);

    // Current beat is the MAX_BEATS-th one of the stream
    assign last_slot_s = (beat_cnt_r >= CNT_LAST);

    // Next-state, grant and next RS beat for the arbiter FSM
    always_comb begin
        state_s      = state_r;
        rr_ptr_s     = rr_ptr_r;
        owner_s      = owner_r;
        beat_cnt_s   = beat_cnt_r;
        err_s        = proto_err_r;
        grant_s      = {NUM_BANK{1'b0}};
        rs_valid_s   = 1'b0;
        rs_sos_s     = 1'b0;
        rs_eos_s     = 1'b0;
        rs_data_s    = rs_data_r;
        rs_node_id_s = rs_node_id_r;
        case (state_r)
            ARB: begin
                if (any_req_s && arb_if.rs_ready) begin
                    grant_s      = win_onehot_s;
                    rs_valid_s   = 1'b1;
                    rs_sos_s     = win_beat_s.sos;
                    rs_eos_s     = win_beat_s.eos;
                    rs_data_s    = win_beat_s.fv_data;
                    rs_node_id_s = win_beat_s.node_id;
                    rr_ptr_s     = win_idx_s + PTR_ONE;
                    err_s        = proto_err_r | ~win_beat_s.sos;
                    if (win_beat_s.eos) begin
                        // single-beat stream: rearm immediately
                        state_s = ARB;
                    end else begin
                        owner_s    = win_idx_s;
                        beat_cnt_s = CNT_ONE;
                        state_s    = STREAM;
                    end
                end else begin
                    // no eligible request or RS not ready: forward nothing
                    rs_valid_s = 1'b0;
                end
            end
            STREAM: begin
                // rs_node_id keeps the id captured on the sos beat
                rs_valid_s = 1'b1;
                rs_sos_s   = 1'b0;
                rs_eos_s   = own_beat_s.eos;
                rs_data_s  = own_beat_s.fv_data;
                beat_cnt_s = (beat_cnt_r == CNT_MAX) ? beat_cnt_r : beat_cnt_r + CNT_ONE;
                err_s      = proto_err_r | own_beat_s.sos | (last_slot_s & ~own_beat_s.eos);
                if (own_beat_s.eos) begin
                    state_s = ARB;
`ifdef EDGE_ARB_TIMEOUT_EN
                end else if (last_slot_s) begin
                    // terminate the runaway stream so the RS sees an eos
                    rs_eos_s = 1'b1;
                    state_s  = ARB;
`endif
                end else begin
                    state_s = STREAM;
                end
            end
            default: begin
                state_s = ARB;
            end
        endcase
    end

    // State, pointer, counter and registered RS outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ARB;
            rr_ptr_r     <= {PTR_W{1'b0}};
            owner_r      <= {PTR_W{1'b0}};
            beat_cnt_r   <= {CNT_W{1'b0}};
            proto_err_r  <= 1'b0;
            rs_valid_r   <= 1'b0;
            rs_sos_r     <= 1'b0;
            rs_eos_r     <= 1'b0;
            rs_data_r    <= {BEAT_W{1'b0}};
            rs_node_id_r <= {NODE_ID_W{1'b0}};
        end else begin
            state_r      <= state_s;
            rr_ptr_r     <= rr_ptr_s;
            owner_r      <= owner_s;
            beat_cnt_r   <= beat_cnt_s;
            proto_err_r  <= err_s;
            rs_valid_r   <= rs_valid_s;
            rs_sos_r     <= rs_sos_s;
            rs_eos_r     <= rs_eos_s;
            rs_data_r    <= rs_data_s;
            rs_node_id_r <= rs_node_id_s;
        end
    end

    // Grant is combinational and suppressed while reset is high
    assign arb_if.bank_grant = reset ? {NUM_BANK{1'b0}} : grant_s;
    assign arb_if.rs_valid   = rs_valid_r;
    assign arb_if.rs_sos     = rs_sos_r;
    assign arb_if.rs_eos     = rs_eos_r;
    assign arb_if.rs_data    = rs_data_r;
    assign arb_if.rs_node_id = rs_node_id_r;
    assign busy              = (state_r != ARB) || rs_valid_r;
    assign proto_err         = proto_err_r;

endmodule

// File: tb/tb_edge_bank_rs_arbiter.sv
// Scoreboard bench for edge_bank_rs_arbiter. Bank behaviour and the arbiter
// reference are modelled with plain ints; expected RS beats are queued and a
// separate monitor pops them whenever rs_valid is seen.
module tb_edge_bank_rs_arbiter;
    import edge_bank_rs_arbiter_pkg::*;

    logic clk;
    logic reset;
    logic busy;
    logic proto_err;

    edge_bank_rs_arbiter_if bus();

    edge_bank_rs_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .arb_if    (bus.master),
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bank2rs_t exp_q[$];

    // bank stimulus state: blen=0 means idle
    int                   blen  [NUM_BANK];
    int                   bidx  [NUM_BANK];
    int                   bflip [NUM_BANK];
    int unsigned          bseed [NUM_BANK];
    logic [NODE_ID_W-1:0] bnode [NUM_BANK];

    // reference arbiter: owner -1 means arbitrating
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    bit m_err   = 1'b0;
    bit m_prev_valid = 1'b0;
    logic [NODE_ID_W-1:0] m_node = '0;
    bit cons  [NUM_BANK];
    bit abort_b [NUM_BANK];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bank2rs_t beat_of(input int b);
        bank2rs_t bt;
        int i = bidx[b];
        bt.sos        = ((i == 0) != (bflip[b] == i));
        bt.eos        = (i == blen[b] - 1);
        bt.fv_data[0] = FV_SIZE'(bseed[b] ^ i);
        bt.fv_data[1] = FV_SIZE'((bseed[b] >> 16) + i);
        bt.node_id    = (i == 0) ? bnode[b] : NODE_ID_W'(bseed[b] + 3 * i);
        return bt;
    endfunction

    function automatic bit any_active();
        bit a = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) a |= (blen[b] != 0);
        return a;
    endfunction

    task automatic start_stream(input int b, input int len, input int node, input int flip);
        blen[b]  = len;
        bidx[b]  = 0;
        bflip[b] = flip;
        bseed[b] = $urandom;
        bnode[b] = NODE_ID_W'(node);
    endtask

    task automatic drive_banks();
        bank2rs_t bt;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (blen[b] != 0) begin
                bt = beat_of(b);
                bus.bank_req[b] = (bidx[b] == 0);
                bus.bank_sos[b] = bt.sos;
                bus.bank_eos[b] = bt.eos;
                bus.bank_data[b*BEAT_W +: BEAT_W] = bt.fv_data;
                bus.bank_node_id[b*NODE_ID_W +: NODE_ID_W] = bt.node_id;
            end else begin
                bus.bank_req[b] = 1'b0;
                bus.bank_sos[b] = 1'b0;
                bus.bank_eos[b] = 1'b0;
                bus.bank_data[b*BEAT_W +: BEAT_W] = '0;
                bus.bank_node_id[b*NODE_ID_W +: NODE_ID_W] = '0;
            end
        end
    endtask

    // Reference step: check registered state, predict grant, queue the beat
    task automatic model_eval();
        logic [NUM_BANK-1:0] eg;
        bank2rs_t bt;
        bit pushed;
        bit last;
        int w;
        bit found;
        eg = '0;
        pushed = 1'b0;
        chk("proto_err", 64'(proto_err), 64'(m_err));
        chk("busy", 64'(busy), 64'((m_owner >= 0) || m_prev_valid));
        for (int b = 0; b < NUM_BANK; b++) begin
            cons[b] = 1'b0;
            abort_b[b] = 1'b0;
        end
        if (reset) begin
            chk("grant_in_reset", 64'(bus.bank_grant), 64'(0));
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_err = 1'b0; m_prev_valid = 1'b0;
            return;
        end
        if (m_owner < 0) begin
            found = 1'b0;
            w = 0;
            for (int i = 0; i < NUM_BANK; i++) begin
                if (!found && bus.bank_req[(m_ptr + i) % NUM_BANK]) begin
                    found = 1'b1;
                    w = (m_ptr + i) % NUM_BANK;
                end
            end
            if (found && bus.rs_ready) begin
                eg[w] = 1'b1;
                bt = beat_of(w);
                cons[w] = 1'b1;
                exp_q.push_back(bt);
                pushed = 1'b1;
                m_ptr = (w + 1) % NUM_BANK;
                if (!bt.sos) m_err = 1'b1;
                if (!bt.eos) begin
                    m_owner = w;
                    m_cnt = 1;
                    m_node = bt.node_id;
                end
            end
        end else begin
            bt = beat_of(m_owner);
            cons[m_owner] = 1'b1;
            if (bt.sos) m_err = 1'b1;
            last = bt.eos;
            if (!bt.eos && (m_cnt + 1 >= MAX_BEATS)) begin
                m_err = 1'b1;
`ifdef EDGE_ARB_TIMEOUT_EN
                bt.eos = 1'b1;
                last = 1'b1;
                abort_b[m_owner] = 1'b1;
`endif
            end
            bt.sos = 1'b0;
            bt.node_id = m_node;
            exp_q.push_back(bt);
            pushed = 1'b1;
            m_cnt = (m_cnt + 1 > MAX_BEATS) ? MAX_BEATS : m_cnt + 1;
            if (last) m_owner = -1;
        end
        chk("bank_grant", 64'(bus.bank_grant), 64'(eg));
        m_prev_valid = pushed;
    endtask

    task automatic advance();
        bank2rs_t bt;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (cons[b]) begin
                bt = beat_of(b);
                bidx[b]++;
                if (bt.eos || abort_b[b] || bidx[b] >= blen[b]) blen[b] = 0;
            end
        end
    endtask

    task automatic cycle();
        drive_banks();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        for (int b = 0; b < NUM_BANK; b++) blen[b] = 0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while ((any_active() || m_owner >= 0) && n < bound) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= bound) begin
            n_err++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
        end
        cycle();
        cycle();
    endtask

    // Monitor: every presented RS beat must match the oldest expected beat
    always @(negedge clk) begin
        if (mon_en && bus.rs_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 64'(1), 64'(0));
            end else begin
                bank2rs_t e;
                bank2rs_t g;
                e = exp_q.pop_front();
                g.sos = bus.rs_sos;
                g.eos = bus.rs_eos;
                g.fv_data = bus.rs_data;
                g.node_id = bus.rs_node_id;
                chk("rs_beat", 64'(g), 64'(e));
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.rs_ready = 1'b0;
        for (int b = 0; b < NUM_BANK; b++) begin
            blen[b] = 0; bidx[b] = 0; bflip[b] = -1; bseed[b] = 0; bnode[b] = '0;
        end
        drive_banks();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rs_valid", 64'(bus.rs_valid), 64'(0));
        chk("reset_rs_sos", 64'(bus.rs_sos), 64'(0));
        chk("reset_rs_eos", 64'(bus.rs_eos), 64'(0));
        chk("reset_rs_data", 64'(bus.rs_data), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_proto_err", 64'(proto_err), 64'(0));
        chk("reset_grant", 64'(bus.bank_grant), 64'(0));
        reset = 1'b0;
        mon_en = 1'b1;

        // bank 2 streams 4 beats, node id 7
        bus.rs_ready = 1'b1;
        start_stream(2, 4, 7, -1);
        run_idle(50);

        // all banks request, 2 beats each; bank 0 refilled for a second turn
        pulse_reset();
        for (int b = 0; b < NUM_BANK; b++) start_stream(b, 2, 16 + b, -1);
        for (int c = 0; c < 9; c++) begin
            if (blen[0] == 0) start_stream(0, 2, 40, -1);
            cycle();
        end
        run_idle(50);

        // RS not ready holds off the grant
        pulse_reset();
        bus.rs_ready = 1'b0;
        start_stream(0, 2, 3, -1);
        repeat (5) cycle();
        bus.rs_ready = 1'b1;
        run_idle(50);

        // single-beat stream from bank 1 with bank 3 also waiting
        pulse_reset();
        start_stream(1, 1, 11, -1);
        start_stream(3, 2, 13, -1);
        run_idle(50);

        // runaway stream: no eos within MAX_BEATS beats
        pulse_reset();
        start_stream(0, MAX_BEATS + 2, 5, -1);
        run_idle(100);
        chk("err_after_runaway", 64'(proto_err), 64'(1));

        // reset during beat 2 of a 4-beat stream
        pulse_reset();
        start_stream(2, 4, 9, -1);
        cycle();
        cycle();
        pulse_reset();
        chk("mid_reset_rs_valid", 64'(bus.rs_valid), 64'(0));
        chk("mid_reset_busy", 64'(busy), 64'(0));
        chk("mid_reset_grant", 64'(bus.bank_grant), 64'(0));
        start_stream(1, 2, 21, -1);
        start_stream(3, 2, 23, -1);
        run_idle(50);

        // randomized traffic with occasional bad sos, runaways and resets
        pulse_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.rs_ready = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < NUM_BANK; b++) begin
                if (blen[b] == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    int fl;
                    len = ($urandom_range(0, 19) == 0) ? MAX_BEATS + 2 : int'($urandom_range(1, 6));
                    fl  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, len - 1)) : -1;
                    start_stream(b, len, int'($urandom_range(0, 1023)), fl);
                end
            end
            if ($urandom_range(0, 299) == 0) pulse_reset();
            else cycle();
        end
        bus.rs_ready = 1'b1;
        run_idle(200);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_bank_rs_arbiter.md
Name: edge_bank_rs_arbiter

Overview:
- Shares the single reservation-station (RS) input port between NUM_BANK edge-buffer banks.
- Each bank raises a request, receives a one-cycle grant pulse, then streams 2-word feature-vector beats, sos on the first beat through eos on the last.
- The arbiter picks one bank round-robin, locks onto it until eos, and forwards the muxed stream to the RS through one register stage.
- Sits between the edge-buffer bank array and the RS.

Parameters:
- NUM_BANK, 4, number of requesting banks (power of two, at least 2)
- FV_SIZE, 16, bits per feature-vector word
- NODE_ID_W, 10, node-id width
- MAX_BEATS, 16, maximum beats per stream (MAX_FV_num/2); sizes the beat counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- bank_req  in  NUM_BANK  per-bank RS request (level; held until granted)
- bank_sos  in  NUM_BANK  per-bank start-of-stream flag
- bank_eos  in  NUM_BANK  per-bank end-of-stream flag
- bank_data  in  NUM_BANK*2*FV_SIZE  per-bank beat, words [0] and [1]
- bank_node_id  in  NUM_BANK*NODE_ID_W  per-bank node id (valid on the sos beat)
- rs_ready  in  1  RS can accept a new stream
- bank_grant  out  NUM_BANK  one-hot grant pulse, combinational
- rs_valid  out  1  registered beat valid
- rs_sos  out  1  registered
- rs_eos  out  1  registered
- rs_data  out  2*FV_SIZE  registered
- rs_node_id  out  NODE_ID_W  registered; holds the sos-beat id for the whole stream
- busy  out  1  state != ARB, or rs_valid
- proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: state=ARB, rr_ptr=0, owner=0, beat_cnt=0. All registered outputs are 0 and bank_grant=0 while reset is high.
- State ARB:
  - Winner is the first set bit of bank_req, scanning from rr_ptr upward with wrap.
  - If any request is set and rs_ready=1: bank_grant=onehot(winner) this cycle; the granted bank drives its sos beat in the same cycle.
  - The arbiter registers that beat: rs_valid=1, rs_sos=bank_sos[w], rs_eos=bank_eos[w], data, node_id.
  - rr_ptr <= (w+1) mod NUM_BANK.
  - If bank_eos[w]=1, stay in ARB (single-beat stream). Otherwise owner<=w, beat_cnt<=1, go to STREAM.
  - If rs_ready=0 or no request: no grant, rs_valid<=0.
- State STREAM:
  - bank_grant=0. Each cycle, register the owner's beat: rs_valid=1, rs_sos=0, rs_eos=bank_eos[owner]; beat_cnt++.
  - On bank_eos[owner]=1, return to ARB. That ARB cycle may grant again, so back-to-back streams have zero bubble at the RS.
  - rs_ready is ignored mid-stream; it only gates new grants.
- Latency: a bank beat appears on rs_* exactly 1 cycle later.
- Requests from non-owner banks during STREAM are ignored and stay pending.
- Arithmetic: rr_ptr wraps modulo NUM_BANK. beat_cnt is clog2(MAX_BEATS)+1 bits and never wraps; it saturates at MAX_BEATS.
- proto_err is set, and stays set until reset, on any of:
  - bank_sos[w]=0 in the grant cycle
  - bank_sos[owner]=1 during STREAM
  - beat_cnt reaches MAX_BEATS without eos
- Error beats are still forwarded unchanged.
- Reset mid-stream aborts the stream: no eos is emitted, rr_ptr returns to 0.

Optional Feature:
- Macro: EDGE_ARB_TIMEOUT_EN
- With the macro defined: in STREAM, if beat_cnt reaches MAX_BEATS and the owner's beat lacks eos, that beat is forwarded with rs_eos forced to 1, proto_err is set, and the FSM returns to ARB. This guarantees the RS never sees an unterminated stream.
- Without the macro: the FSM stays in STREAM until the owner's eos. proto_err is still set at MAX_BEATS.

Decomposition:
- Shared package holds:
  - the Bank2RS-style beat typedef (sos, eos, FV_data[2], Node_id)
  - NUM_BANK, FV_SIZE, NODE_ID_W, MAX_BEATS
  - the arbiter state enum {ARB, STREAM}
- One sub-module, rr_priority_pick: request vector + rr_ptr in, one-hot winner + index + any_req out, purely combinational.

Test Plan:
- Reset, then bank_req=4'b0100, rs_ready=1; bank 2 streams 4 beats, node_id=7 -> bank_grant=4'b0100 for one cycle; rs_valid high 4 cycles starting 1 cycle later; rs_sos on beat 1, rs_eos on beat 4; rs_node_id=7 throughout; rr_ptr=3.
- bank_req=4'b1111 held, each bank sends 2 beats -> grants in order 0,1,2,3,0; no idle cycle between eos and the next sos at the RS.
- rs_ready=0 with bank_req=4'b0001 for 5 cycles -> no grant, rs_valid=0; rs_ready=1 -> grant on that same cycle.
- Single-beat stream (sos=eos=1) from bank 1, bank 3 also requesting -> 1-cycle rs_valid with sos=eos=1; bank 3 granted the next cycle.
- Owner omits eos for MAX_BEATS beats -> proto_err=1. With EDGE_ARB_TIMEOUT_EN: beat 16 is forwarded with rs_eos=1, FSM returns to ARB. Without it: FSM stays in STREAM.
- Reset asserted on beat 2 of a 4-beat stream -> next cycle rs_valid=0, busy=0, bank_grant=0; the next request is arbitrated from bank 0.
